// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared definitions for the next-PC redirect controller.
// Holds the PCSrc select encodings, the kernel entry vectors and the
// interrupt FSM state encoding.
package pc_redirect_ctrl_pkg;

  localparam int unsigned PCSRC_W = 3;
  localparam int unsigned XLEN    = 32;
  localparam int unsigned JT_W    = 26;

  localparam logic [PCSRC_W-1:0] PCSRC_PC4    = 3'b000;
  localparam logic [PCSRC_W-1:0] PCSRC_BRANCH = 3'b001;
  localparam logic [PCSRC_W-1:0] PCSRC_JUMP   = 3'b010;
  localparam logic [PCSRC_W-1:0] PCSRC_JR     = 3'b011;
  localparam logic [PCSRC_W-1:0] PCSRC_INT    = 3'b100;
  localparam logic [PCSRC_W-1:0] PCSRC_EXC    = 3'b101;

  localparam logic [XLEN-1:0] INT_VECTOR = 32'h8000_0004;
  localparam logic [XLEN-1:0] EXC_VECTOR = 32'h8000_0008;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PEND   = 2'd1,
    ST_ENTER  = 2'd2,
    ST_KERNEL = 2'd3
  } irq_state_e;

endpackage

// File: rtl/pc_redirect_ctrl_irq_sync.sv
// N-stage flip-flop synchronizer for an asynchronous level input.
// Ports: clk, reset (async active-high), d (async input), q (synchronized).
module irq_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the raw input in at bit 0; the oldest sample appears at the top.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Next-PC redirect controller for the 5-stage MIPS pipeline.
// Arbitrates EX branch, ID illegal/JR/J redirects and the timer interrupt,
// drives PCSrc, target pass-through buses and flush strobes, and owns the
// interrupt FSM plus the EPC register.
// Ports: clk, reset (async active-high), irq (async level), ID/EX request
// and operand inputs, stall, pc_kernel; outputs PCSrc, ConBA, JT, DatabusA,
// flush_if, flush_id, epc_we, epc (registered), irq_pending.
module pc_redirect_ctrl
  import pc_redirect_ctrl_pkg::*;
#(
  parameter int unsigned IRQ_SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             irq,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic             id_jump,
  input  logic             id_jr,
  input  logic             id_illegal,
  input  logic [JT_W-1:0]  id_jt,
  input  logic [XLEN-1:0]  id_rs_data,
  input  logic             ex_branch_taken,
  input  logic             ex_branch,
  input  logic [XLEN-1:0]  ex_conba,
  input  logic             stall,
  input  logic             pc_kernel,
  output logic [PCSRC_W-1:0] PCSrc,
  output logic [XLEN-1:0]  ConBA,
  output logic [JT_W-1:0]  JT,
  output logic [XLEN-1:0]  DatabusA,
  output logic             flush_if,
  output logic             flush_id,
  output logic             epc_we,
  output logic [XLEN-1:0]  epc,
  output logic             irq_pending
);

  logic            irq_s;
  irq_state_e      state_q, state_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [PCSRC_W-1:0] pcsrc_c;
  logic            flush_if_c;
  logic            flush_id_c;
  logic            epc_we_c;
  logic            int_accept_c;

  irq_sync #(
    .STAGES(IRQ_SYNC_STAGES)
  ) u_irq_sync (
    .clk  (clk),
    .reset(reset),
    .d    (irq),
    .q    (irq_s)
  );

  // Redirect priority and interrupt FSM next state.
  always_comb begin
    pcsrc_c      = PCSRC_PC4;
    flush_if_c   = 1'b0;
    flush_id_c   = 1'b0;
    epc_we_c     = 1'b0;
    epc_d        = epc_q;
    int_accept_c = 1'b0;
    state_d      = state_q;

    if (ex_branch_taken) begin
      // A taken branch squashes ID, so any ID request there is moot.
      pcsrc_c    = PCSRC_BRANCH;
      flush_if_c = 1'b1;
      flush_id_c = 1'b1;
    end else if (id_illegal && id_valid && !stall) begin
      pcsrc_c    = PCSRC_EXC;
      flush_if_c = 1'b1;
      flush_id_c = 1'b1;
      epc_we_c   = 1'b1;
      epc_d      = id_pc + 32'd4;
    end else if ((state_q == ST_PEND) && id_valid && !stall && !ex_branch && !pc_kernel) begin
      // Wait for a branch in EX to resolve so EPC never points into a shadow.
      pcsrc_c      = PCSRC_INT;
      flush_if_c   = 1'b1;
      flush_id_c   = 1'b1;
      epc_we_c     = 1'b1;
      epc_d        = id_pc;
      int_accept_c = 1'b1;
    end else if (id_jr && id_valid && !stall) begin
      pcsrc_c    = PCSRC_JR;
      flush_if_c = 1'b1;
    end else if (id_jump && id_valid && !stall) begin
      pcsrc_c    = PCSRC_JUMP;
      flush_if_c = 1'b1;
    end

    case (state_q)
      ST_RUN:    if (irq_s && !pc_kernel) state_d = ST_PEND;
      ST_PEND:   if (int_accept_c)        state_d = ST_ENTER;
      ST_ENTER:  if (pc_kernel)           state_d = ST_KERNEL;
      ST_KERNEL: if (!pc_kernel)          state_d = ST_RUN;
      default:                            state_d = ST_RUN;
    endcase
  end

  // FSM state and EPC registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
    end
  end

  assign PCSrc       = pcsrc_c;
  assign flush_if    = flush_if_c;
  assign flush_id    = flush_id_c;
  assign epc_we      = epc_we_c;
  assign ConBA       = ex_conba;
  assign JT          = id_jt;
  assign DatabusA    = id_rs_data;
  assign epc         = epc_q;
  assign irq_pending = (state_q == ST_PEND);

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Self-checking bench for pc_redirect_ctrl: directed scenarios with literal
// expectations, then randomized traffic checked against a behavioural model.
module tb_pc_redirect_ctrl;

  localparam int unsigned SYNC = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        irq = 1'b0;
  logic        id_valid = 1'b0;
  logic [31:0] id_pc = '0;
  logic        id_jump = 1'b0;
  logic        id_jr = 1'b0;
  logic        id_illegal = 1'b0;
  logic [25:0] id_jt = '0;
  logic [31:0] id_rs_data = '0;
  logic        ex_branch_taken = 1'b0;
  logic        ex_branch = 1'b0;
  logic [31:0] ex_conba = '0;
  logic        stall = 1'b0;
  logic        pc_kernel = 1'b0;

  logic [2:0]  PCSrc;
  logic [31:0] ConBA;
  logic [25:0] JT;
  logic [31:0] DatabusA;
  logic        flush_if, flush_id, epc_we;
  logic [31:0] epc;
  logic        irq_pending;

  int total = 0;
  int bad = 0;

  pc_redirect_ctrl #(.IRQ_SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .irq(irq), .id_valid(id_valid), .id_pc(id_pc),
    .id_jump(id_jump), .id_jr(id_jr), .id_illegal(id_illegal), .id_jt(id_jt),
    .id_rs_data(id_rs_data), .ex_branch_taken(ex_branch_taken),
    .ex_branch(ex_branch), .ex_conba(ex_conba), .stall(stall),
    .pc_kernel(pc_kernel), .PCSrc(PCSrc), .ConBA(ConBA), .JT(JT),
    .DatabusA(DatabusA), .flush_if(flush_if), .flush_id(flush_id),
    .epc_we(epc_we), .epc(epc), .irq_pending(irq_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Interrupt life cycle: idle -> waiting for a safe point -> entering handler
  // -> inside handler -> idle.
  localparam int PH_IDLE = 0, PH_WAIT = 1, PH_ENTRY = 2, PH_HANDLER = 3;

  typedef struct {
    logic [2:0]  pcsrc;
    logic        fif;
    logic        fid;
    logic        we;
    logic [31:0] epcv;
    logic        accept;
  } exp_t;

  int          m_phase = PH_IDLE;
  logic [31:0] m_epc = '0;
  bit          irq_seen[$];   // raw irq samples taken at each clock edge

  function automatic exp_t model_out();
    exp_t e;
    e = '{pcsrc: 3'd0, fif: 1'b0, fid: 1'b0, we: 1'b0, epcv: 32'd0, accept: 1'b0};
    if (ex_branch_taken) begin
      e.pcsrc = 3'd1; e.fif = 1; e.fid = 1;
    end else if (id_illegal && id_valid && !stall) begin
      e.pcsrc = 3'd5; e.fif = 1; e.fid = 1; e.we = 1; e.epcv = id_pc + 32'd4;
    end else if (m_phase == PH_WAIT && id_valid && !stall && !ex_branch && !pc_kernel) begin
      e.pcsrc = 3'd4; e.fif = 1; e.fid = 1; e.we = 1; e.epcv = id_pc; e.accept = 1;
    end else if (id_jr && id_valid && !stall) begin
      e.pcsrc = 3'd3; e.fif = 1;
    end else if (id_jump && id_valid && !stall) begin
      e.pcsrc = 3'd2; e.fif = 1;
    end
    return e;
  endfunction

  // irq as seen SYNC edges ago (0 if fewer samples since reset).
  function automatic bit irq_delayed();
    if (irq_seen.size() < SYNC) return 1'b0;
    return irq_seen[irq_seen.size() - SYNC];
  endfunction

  always @(posedge clk or posedge reset) begin : model_upd
    exp_t e;
    if (reset) begin
      m_phase = PH_IDLE;
      m_epc   = '0;
      irq_seen.delete();
    end else begin
      e = model_out();
      if (e.we) m_epc = e.epcv;
      case (m_phase)
        PH_IDLE:    if (irq_delayed() && !pc_kernel) m_phase = PH_WAIT;
        PH_WAIT:    if (e.accept) m_phase = PH_ENTRY;
        PH_ENTRY:   if (pc_kernel) m_phase = PH_HANDLER;
        default:    if (!pc_kernel) m_phase = PH_IDLE;
      endcase
      irq_seen.push_back(irq);
      if (irq_seen.size() > 8) void'(irq_seen.pop_front());
    end
  end

  // Every cycle, away from the active edge, compare against the model.
  always @(negedge clk) begin : cmp
    exp_t e;
    e = model_out();
    check("m_pcsrc",    32'(PCSrc),    32'(e.pcsrc));
    check("m_flush_if", 32'(flush_if), 32'(e.fif));
    check("m_flush_id", 32'(flush_id), 32'(e.fid));
    check("m_epc_we",   32'(epc_we),   32'(e.we));
    check("m_epc",      epc,           m_epc);
    check("m_pending",  32'(irq_pending), 32'(m_phase == PH_WAIT));
    check("m_conba",    ConBA,         ex_conba);
    check("m_jt",       32'(JT),       32'(id_jt));
    check("m_databusa", DatabusA,      id_rs_data);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    id_valid = 0; id_jump = 0; id_jr = 0; id_illegal = 0;
    ex_branch = 0; ex_branch_taken = 0; stall = 0;
  endtask

  initial begin
    // 1: reset with irq high, then 3-cycle latency to pending
    #1 reset = 1; irq = 1;
    tick(); tick();
    #1;
    check("rst_pcsrc", 32'(PCSrc), 32'd0);
    check("rst_pending", 32'(irq_pending), 32'd0);
    check("rst_epc", epc, 32'd0);
    tick(); reset = 0;
    tick(); check("lat1", 32'(irq_pending), 32'd0);
    tick(); check("lat2", 32'(irq_pending), 32'd0);
    tick(); check("lat3", 32'(irq_pending), 32'd1);

    // 2: taken branch beats jump and pending interrupt
    id_valid = 1; id_jump = 1; ex_branch = 1; ex_branch_taken = 1; ex_conba = 32'h40;
    #1;
    check("br_pcsrc", 32'(PCSrc), 32'd1);
    check("br_conba", ConBA, 32'h40);
    check("br_flush", 32'({flush_if, flush_id}), 32'd3);
    tick(); check("br_still_pend", 32'(irq_pending), 32'd1);

    // 3: accept deferred while EX holds a branch
    id_jump = 0; ex_branch_taken = 0; id_pc = 32'h100;
    #1 check("defer1", 32'(PCSrc), 32'd0);
    tick(); #1 check("defer2", 32'(PCSrc), 32'd0);
    tick(); ex_branch = 0;
    #1;
    check("acc_pcsrc", 32'(PCSrc), 32'd4);
    check("acc_we", 32'(epc_we), 32'd1);
    tick();
    check("acc_epc", epc, 32'h100);
    check("acc_left_pend", 32'(irq_pending), 32'd0);

    // 6: no second accept while in kernel with irq still high
    pc_kernel = 1;
    for (int i = 0; i < 10; i++) begin
      tick(); #1 check("kern_no_acc", 32'(PCSrc), 32'd0);
    end
    pc_kernel = 0;
    tick(); check("ret_run", 32'(irq_pending), 32'd0);
    tick(); check("ret_pend", 32'(irq_pending), 32'd1);

    // 4: exception in PEND wins and keeps PEND
    id_illegal = 1; id_pc = 32'h20;
    #1 check("exc_pcsrc", 32'(PCSrc), 32'd5);
    tick();
    check("exc_epc", epc, 32'h24);
    check("exc_pend", 32'(irq_pending), 32'd1);
    id_illegal = 0;
    #1 check("late_acc", 32'(PCSrc), 32'd4);
    tick(); irq = 0; pc_kernel = 1;
    tick(); tick(); tick(); pc_kernel = 0;
    tick(); check("idle_again", 32'(irq_pending), 32'd0);

    // 5: JR held by stall, then released
    id_jr = 1; stall = 1; id_rs_data = 32'hDEAD_BEEF;
    #1 check("jr_stall", 32'(PCSrc), 32'd0);
    tick(); stall = 0;
    #1;
    check("jr_pcsrc", 32'(PCSrc), 32'd3);
    check("jr_bus", DatabusA, 32'hDEAD_BEEF);
    check("jr_flush", 32'({flush_if, flush_id}), 32'd2);

    // reset mid-PEND drops the pending interrupt
    quiet(); irq = 1;
    tick(); tick(); tick();
    check("pre_rst_pend", 32'(irq_pending), 32'd1);
    reset = 1; #1 check("rst_drop", 32'(irq_pending), 32'd0);
    tick(); reset = 0; irq = 0;
    tick(); tick(); tick();

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      tick();
      reset = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 15) == 0) irq = ~irq;
      id_valid = ($urandom_range(0, 3) != 0);
      id_pc = {$urandom_range(0, 32'h3fff), 2'b00};
      id_jump = ($urandom_range(0, 5) == 0);
      id_jr = ($urandom_range(0, 5) == 0);
      id_illegal = ($urandom_range(0, 11) == 0);
      id_jt = 26'($urandom);
      id_rs_data = $urandom;
      ex_branch = ($urandom_range(0, 3) == 0);
      ex_branch_taken = ex_branch && ($urandom_range(0, 1) == 0);
      ex_conba = $urandom;
      stall = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 5) == 0) pc_kernel = ~pc_kernel;
    end
    tick(); reset = 0; quiet();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_redirect_ctrl.md
# pc_redirect_ctrl

Generates the next-PC selection that the pipeline program counter consumes. It arbitrates redirect requests from ID (J/JAL, JR/JALR, illegal opcode) and EX (conditional branch), plus the external timer interrupt, and drives `PCSrc`, the target buses and the pipeline flush strobes. It also owns the interrupt-pending/kernel-entry state machine and the exception return address (EPC, written to `$26`). It sits between the hazard/control logic and the program counter in the 5-stage MIPS pipeline.

## Interface

**Parameters**
- `IRQ_SYNC_STAGES`, default 2: flip-flop stages on `irq`; minimum 2.

**Ports**
- `clk`  in  1  pipeline clock.
- `reset`  in  1  asynchronous, active-high reset.
- `irq`  in  1  timer interrupt, level, asynchronous to `clk`.
- `id_valid`  in  1  ID holds a real instruction, not a bubble.
- `id_pc`  in  32  PC of the ID instruction.
- `id_jump`  in  1  J/JAL in ID.
- `id_jr`  in  1  JR/JALR in ID.
- `id_illegal`  in  1  undefined opcode in ID.
- `id_jt`  in  26  jump target field.
- `id_rs_data`  in  32  forwarded rs value for JR.
- `ex_branch_taken`  in  1  branch in EX resolved taken.
- `ex_branch`  in  1  EX holds a branch, taken or not.
- `ex_conba`  in  32  branch target.
- `stall`  in  1  load-use stall active.
- `pc_kernel`  in  1  bit 31 of current PC.
- `PCSrc`  out  3  next-PC select (encoding below).
- `ConBA`  out  32  equals `ex_conba`.
- `JT`  out  26  equals `id_jt`.
- `DatabusA`  out  32  equals `id_rs_data`.
- `flush_if`  out  1  squash the instruction in IF.
- `flush_id`  out  1  squash the instruction in ID.
- `epc_we`  out  1  write `epc` into `$26`.
- `epc`  out  32  return address, registered.
- `irq_pending`  out  1  high in state PEND.

## Operation

**PCSrc encoding**
- 000: PC+4
- 001: branch
- 010: jump
- 011: register (JR)
- 100: interrupt (0x80000004)
- 101: exception (0x80000008)

**Priority** (combinational, highest first):
1. `ex_branch_taken` → 001; `flush_if`=`flush_id`=1.
2. `id_illegal & id_valid & ~stall` → 101; both flushes; `epc_we`=1; `epc` ← `id_pc`+4.
3. Interrupt accept: state PEND & `id_valid` & ~`stall` & ~`ex_branch` & ~`pc_kernel` → 100; both flushes; `epc_we`=1; `epc` ← `id_pc`.
4. `id_jr & id_valid & ~stall` → 011; `flush_if`=1.
5. `id_jump & id_valid & ~stall` → 010; `flush_if`=1.
6. Otherwise 000; no flushes; `epc_we`=0.

**Rules**
- An illegal opcode in ID is ignored when a taken branch in EX squashes ID.
- Exceptions are taken in kernel mode too; interrupts are not.

**FSM** (`irq_s` is the synchronized `irq`)
- RUN: `irq_s` & ~`pc_kernel` → PEND.
- PEND: interrupt accepted → ENTER. An exception accepted in the same cycle wins, and the state stays PEND.
- ENTER: one cycle; `pc_kernel`=1 → KERNEL, else stays ENTER.
- KERNEL: `pc_kernel`=0 (handler returned via `jr $26`) → RUN.
- `irq` dropping while in PEND does not cancel PEND. An accepted interrupt is serviced exactly once per RUN→PEND entry.

**Reset**
- State RUN; sync flops 0; `epc` = 0x00000000.
- With all inputs low: `PCSrc`=000, flushes 0, `epc_we`=0, `irq_pending`=0.
- Reset asserted mid-PEND or mid-KERNEL drops the pending interrupt.

## Timing

- `PCSrc`, target buses, flushes and `epc_we` are combinational, in the same cycle as the request. The PC registers the choice on the next `clk` edge.
- `epc` updates on the `clk` edge where `epc_we`=1 and is valid the following cycle.
- `irq` to `irq_pending` latency: `IRQ_SYNC_STAGES`+1 cycles when in RUN and not in kernel mode.
- ENTER→KERNEL takes exactly 1 cycle after accept under normal operation.

## Structure

- Shared package: the PCSrc encodings, the vectors 0x80000004 and 0x80000008, and the FSM state encoding (2 bits).
- Sub-module `irq_sync`: parameterized N-stage synchronizer, reset to 0.
- The remaining arbitration and FSM logic stays in this block.

## Test plan

1. Reset with `irq`=1 → `PCSrc`=000, `irq_pending`=0. After release, `irq_pending`=1 exactly 3 cycles later.
2. `ex_branch_taken`=1 together with `id_jump`=1 and `ex_conba`=0x00000040 → `PCSrc`=001, `ConBA`=0x00000040, `flush_if`=`flush_id`=1.
3. In PEND, `id_pc`=0x00000100 and `ex_branch`=1 for 2 cycles, then `ex_branch`=0 → accept on the 3rd cycle: `PCSrc`=100, `epc`=0x00000100 next cycle, state ENTER.
4. `id_illegal` with `id_pc`=0x00000020 in PEND → `PCSrc`=101, `epc`=0x00000024. State stays PEND; the interrupt is accepted later.
5. `id_jr` with `stall`=1 → `PCSrc`=000. When `stall`=0, `PCSrc`=011 and `DatabusA`=`id_rs_data`.
6. Interrupt accepted, `pc_kernel` 1 for 10 cycles with `irq` still high → no second accept. `pc_kernel` goes 0 → RUN, then PEND again.
